// File: rtl/fm_mean_ctrl.sv
// Job controller for a per-channel mean datapath: feeds feature-map beats into
// the datapath, collects one result per channel, and credit-limits the results.
module fm_mean_ctrl #(
  parameter int bitwidth  = 16,
  parameter int N         = 8,
  parameter int LEN_W     = 16,
  parameter int CH_W      = 12,
  parameter int RES_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_start,
  input  logic [LEN_W-1:0]      cfg_len,
  input  logic [CH_W-1:0]       cfg_num_ch,
  input  logic [bitwidth-1:0]   cfg_h_param,
  input  logic [N*bitwidth-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [N*bitwidth-1:0] dp_in,
  output logic                  dp_in_valid,
  output logic                  dp_in_last,
  output logic [bitwidth-1:0]   dp_h_param,
  input  logic [bitwidth-1:0]   dp_out,
  input  logic                  dp_out_valid,
  input  logic                  dp_out_last,
  output logic [bitwidth-1:0]   m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  err_ovf
);

  localparam int AW = $clog2(RES_DEPTH);
  localparam int CW = $clog2(RES_DEPTH) + 1;
  localparam logic [CW-1:0] CRED_MAX = CW'(RES_DEPTH);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic [CH_W-1:0]       num_ch_q, num_ch_d;
  logic [bitwidth-1:0]   h_q, h_d;
  logic [LEN_W-1:0]      beat_q, beat_d;
  logic [CH_W-1:0]       ch_q, ch_d;
  logic [CH_W-1:0]       popped_q, popped_d;
  logic [CW-1:0]         credits_q, credits_d;
  logic                  done_d;
  logic                  done_q;
  logic                  err_ovf_q;
  logic [N*bitwidth-1:0] dp_in_q;
  logic                  dp_in_valid_q, dp_in_last_q;
  logic [AW:0]           wr_ptr_q, rd_ptr_q, fifo_count;
  logic [bitwidth-1:0]   mem [RES_DEPTH];

  logic fifo_empty, fifo_full, fire, chan_last, pop, push, push_ok;

  assign fifo_count = wr_ptr_q - rd_ptr_q;
  assign fifo_empty = (fifo_count == '0);
  assign fifo_full  = (fifo_count == CRED_MAX);
  assign s_ready    = (state_q == S_STREAM) && (credits_q != '0) && (ch_q < num_ch_q);
  assign fire       = s_valid && s_ready;
  assign chan_last  = fire && (beat_q == len_q - LEN_W'(1));
  assign pop        = !fifo_empty && m_ready;
  assign push       = dp_out_valid && dp_out_last;
  assign push_ok    = push && !fifo_full;

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    num_ch_d  = num_ch_q;
    h_d       = h_q;
    beat_d    = beat_q;
    ch_d      = ch_q;
    done_d    = 1'b0;
    popped_d  = popped_q;
    // A pop returns a credit; clamp guards against stale results popped while idle.
    credits_d = credits_q + CW'(pop && (credits_q < CRED_MAX)) - CW'(chan_last);
    if (pop && (state_q != S_IDLE)) popped_d = popped_q + CH_W'(1);

    case (state_q)
      S_IDLE: begin
        if (cfg_start) begin
          if ((cfg_len != '0) && (cfg_num_ch != '0)) begin
            len_d     = cfg_len;
            num_ch_d  = cfg_num_ch;
            h_d       = cfg_h_param;
            beat_d    = '0;
            ch_d      = '0;
            popped_d  = '0;
            credits_d = CRED_MAX;
            state_d   = S_STREAM;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_STREAM: begin
        if (chan_last) begin
          beat_d = '0;
          ch_d   = ch_q + CH_W'(1);
          if (ch_q == num_ch_q - CH_W'(1)) state_d = S_DRAIN;
        end else if (fire) begin
          beat_d = beat_q + LEN_W'(1);
        end
      end
      S_DRAIN: begin
        if (popped_q == num_ch_q) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      len_q         <= '0;
      num_ch_q      <= '0;
      h_q           <= '0;
      beat_q        <= '0;
      ch_q          <= '0;
      popped_q      <= '0;
      credits_q     <= CRED_MAX;
      done_q        <= 1'b0;
      err_ovf_q     <= 1'b0;
      dp_in_q       <= '0;
      dp_in_valid_q <= 1'b0;
      dp_in_last_q  <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      num_ch_q      <= num_ch_d;
      h_q           <= h_d;
      beat_q        <= beat_d;
      ch_q          <= ch_d;
      popped_q      <= popped_d;
      credits_q     <= credits_d;
      done_q        <= done_d;
      dp_in_valid_q <= fire;
      dp_in_last_q  <= chan_last;
      if (fire) dp_in_q <= s_data;
      if (push && fifo_full) err_ovf_q <= 1'b1;
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q[AW-1:0]] <= dp_out;
  end

  assign m_valid     = !fifo_empty;
  assign m_data      = fifo_empty ? '0 : mem[rd_ptr_q[AW-1:0]];
  assign dp_in       = dp_in_q;
  assign dp_in_valid = dp_in_valid_q;
  assign dp_in_last  = dp_in_last_q;
  assign dp_h_param  = h_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign err_ovf     = err_ovf_q;

endmodule

// File: tb/tb_fm_mean_ctrl.sv
// Directed bench for fm_mean_ctrl with a one-cycle stand-in mean datapath
// (result = lane0 of the channel's last beat XOR dp_h_param).
module tb_fm_mean_ctrl;
  localparam int BW = 16, N = 8, LEN_W = 16, CH_W = 12, RD = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              cfg_start;
  logic [LEN_W-1:0]  cfg_len;
  logic [CH_W-1:0]   cfg_num_ch;
  logic [BW-1:0]     cfg_h_param;
  logic [N*BW-1:0]   s_data;
  logic              s_valid, s_ready;
  logic [N*BW-1:0]   dp_in;
  logic              dp_in_valid, dp_in_last;
  logic [BW-1:0]     dp_h_param, dpo_data, m_data;
  logic              dpo_valid, dpo_last, m_valid, m_ready, busy, done, err_ovf;

  int asserts = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  fm_mean_ctrl #(.bitwidth(BW), .N(N), .LEN_W(LEN_W), .CH_W(CH_W), .RES_DEPTH(RD)) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_len(cfg_len), .cfg_num_ch(cfg_num_ch),
    .cfg_h_param(cfg_h_param), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .dp_in(dp_in), .dp_in_valid(dp_in_valid), .dp_in_last(dp_in_last), .dp_h_param(dp_h_param),
    .dp_out(dpo_data), .dp_out_valid(dpo_valid), .dp_out_last(dpo_last),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .busy(busy), .done(done), .err_ovf(err_ovf));

  // Stand-in datapath: also emits non-last valid pulses, which must be ignored.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      dpo_valid <= 1'b0;
      dpo_last  <= 1'b0;
      dpo_data  <= '0;
    end else begin
      dpo_valid <= dp_in_valid;
      dpo_last  <= dp_in_last;
      dpo_data  <= dp_in[BW-1:0] ^ dp_h_param;
    end
  end

  function automatic logic [N*BW-1:0] mk_beat(int ch, int beat);
    logic [N*BW-1:0] v;
    logic [15:0] t;
    t = 16'h1000 | 16'(ch << 4) | 16'(beat);
    for (int k = 0; k < N; k++) v[k*BW +: BW] = t + 16'(k * 256);
    return v;
  endfunction

  function automatic logic [15:0] exp_res(int ch, int len, logic [15:0] h);
    return (16'h1000 | 16'(ch << 4) | 16'(len - 1)) ^ h;
  endfunction

  // Monitor, sampled on the falling edge.
  int n_fire, n_dpv, n_dplast, n_done, mirror_err, cur_len;
  bit busy_seen, dpv_seen;
  logic [15:0] res_q[$];
  logic prev_fire, prev_last;
  logic [N*BW-1:0] prev_data;

  always @(negedge clk) begin
    if (rst) begin
      prev_fire = 1'b0;
    end else begin
      if (dp_in_valid) n_dpv++;
      if (dp_in_last) n_dplast++;
      if (dp_in_valid !== prev_fire) mirror_err++;
      else if (prev_fire && (dp_in !== prev_data || dp_in_last !== prev_last)) mirror_err++;
      if (dp_in_last && !dp_in_valid) mirror_err++;
      if (done) n_done++;
      if (busy) busy_seen = 1'b1;
      if (dp_in_valid) dpv_seen = 1'b1;
      if (m_valid && m_ready) res_q.push_back(m_data);
      prev_fire = s_valid && s_ready;
      if (prev_fire) begin
        n_fire++;
        prev_data = s_data;
        prev_last = (s_data[3:0] == 4'(cur_len - 1));
      end
    end
  end

  int drv_ch, drv_beat;

  task automatic clear_mon();
    n_fire = 0; n_dpv = 0; n_dplast = 0; n_done = 0; mirror_err = 0;
    busy_seen = 1'b0; dpv_seen = 1'b0;
    res_q.delete();
  endtask

  task automatic start_job(input int len, input int nch, input logic [15:0] h);
    cfg_len = LEN_W'(len); cfg_num_ch = CH_W'(nch); cfg_h_param = h; cfg_start = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    drv_ch = 0; drv_beat = 0; cur_len = len;
  endtask

  task automatic drive_beats(input int len, input int nch, input int budget, input bit rnd);
    int cyc;
    bit fired;
    cyc = 0;
    while (drv_ch < nch && cyc < budget) begin
      s_data  = mk_beat(drv_ch, drv_beat);
      s_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      fired = s_valid && s_ready;
      @(posedge clk); #1;
      cyc++;
      if (fired) begin
        if (drv_beat == len - 1) begin drv_beat = 0; drv_ch++; end
        else drv_beat++;
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (done) ok = 1'b1;
    end
    @(posedge clk); #1;
  endtask

  task automatic check_results(input string name, input int nch, input int len, input logic [15:0] h);
    asserts++;
    if (res_q.size() != nch) begin
      errors++;
      $display("FAIL %s_count: got %0d results, expected %0d", name, res_q.size(), nch);
    end
    for (int i = 0; i < nch; i++) begin
      logic [15:0] got;
      got = (i < res_q.size()) ? res_q[i] : 16'hxxxx;
      asserts++;
      if (got !== exp_res(i, len, h)) begin
        errors++;
        $display("FAIL %s_res%0d: got %h expected %h", name, i, got, exp_res(i, len, h));
      end
    end
  endtask

  task automatic check_job(input string name, input int len, input int nch, input logic [15:0] h, input bit ok);
    asserts++;
    if (!ok) begin errors++; $display("FAIL %s_done_timeout: done=0 expected 1", name); end
    asserts++;
    if (n_fire != len * nch) begin errors++; $display("FAIL %s_beats: got %0d expected %0d", name, n_fire, len * nch); end
    asserts++;
    if (n_dpv != len * nch) begin errors++; $display("FAIL %s_dp_valid: got %0d expected %0d", name, n_dpv, len * nch); end
    asserts++;
    if (n_dplast != nch) begin errors++; $display("FAIL %s_dp_last: got %0d expected %0d", name, n_dplast, nch); end
    asserts++;
    if (mirror_err != 0) begin errors++; $display("FAIL %s_dp_mirror: got %0d errors expected 0", name, mirror_err); end
    asserts++;
    if (n_done != 1) begin errors++; $display("FAIL %s_done_count: got %0d expected 1", name, n_done); end
    asserts++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL %s_idle_after: done=%b busy=%b expected 0 0", name, done, busy);
    end
    check_results(name, nch, len, h);
    $display("job %s len=%0d ch=%0d beats=%0d results=%0d", name, len, nch, n_fire, res_q.size());
  endtask

  task automatic check_reset_outputs(input string name);
    logic [N*BW+2*BW+6:0] v;
    v = {s_ready, dp_in, dp_in_valid, dp_in_last, dp_h_param, m_valid, m_data, busy, done, err_ovf};
    asserts++;
    if (v !== '0) begin errors++; $display("FAIL %s: outputs=%h expected 0", name, v); end
  endtask

  task automatic test_reset();
    rst = 1'b1; cfg_start = 1'b0; cfg_len = '0; cfg_num_ch = '0; cfg_h_param = '0;
    s_data = '0; s_valid = 1'b0; m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset_outputs");
    rst = 1'b0;
    @(posedge clk); #1;
    asserts++;
    if (busy !== 1'b0 || s_ready !== 1'b0) begin
      errors++; $display("FAIL reset_idle: busy=%b s_ready=%b expected 0 0", busy, s_ready);
    end
    $display("reset released busy=%b s_ready=%b", busy, s_ready);
  endtask

  task automatic test_basic();
    bit ok;
    clear_mon();
    m_ready = 1'b1;
    start_job(4, 2, 16'h3C00);
    asserts++;
    if (busy !== 1'b1 || dp_h_param !== 16'h3C00) begin
      errors++; $display("FAIL basic_stream_entry: busy=%b h=%h expected 1 3c00", busy, dp_h_param);
    end
    drive_beats(4, 2, 50, 1'b0);
    wait_done(100, ok);
    check_job("basic", 4, 2, 16'h3C00, ok);
  endtask

  task automatic test_credits();
    bit ok;
    clear_mon();
    m_ready = 1'b0;
    start_job(1, 6, 16'h00FF);
    drive_beats(1, 6, 20, 1'b0);
    asserts++;
    if (n_fire != RD) begin errors++; $display("FAIL credits_stall_beats: got %0d expected %0d", n_fire, RD); end
    asserts++;
    if (s_ready !== 1'b0 || m_valid !== 1'b1) begin
      errors++; $display("FAIL credits_stall_state: s_ready=%b m_valid=%b expected 0 1", s_ready, m_valid);
    end
    asserts++;
    if (err_ovf !== 1'b0) begin errors++; $display("FAIL credits_ovf: got %b expected 0", err_ovf); end
    $display("credits stalled after %0d channels s_ready=%b", n_fire, s_ready);
    m_ready = 1'b1;
    drive_beats(1, 6, 50, 1'b0);
    wait_done(100, ok);
    check_job("credits", 1, 6, 16'h00FF, ok);
  endtask

  task automatic test_zero_cfg();
    clear_mon();
    for (int i = 0; i < 2; i++) begin
      cfg_len = (i == 0) ? LEN_W'(0) : LEN_W'(3);
      cfg_num_ch = (i == 0) ? CH_W'(3) : CH_W'(0);
      cfg_start = 1'b1;
      @(posedge clk); #1;
      cfg_start = 1'b0;
      asserts++;
      if (done !== 1'b1) begin errors++; $display("FAIL zero_cfg%0d_done: got %b expected 1", i, done); end
      @(posedge clk); #1;
      asserts++;
      if (done !== 1'b0) begin errors++; $display("FAIL zero_cfg%0d_pulse: got %b expected 0", i, done); end
      $display("zero cfg len=%0d ch=%0d done pulsed", cfg_len, cfg_num_ch);
    end
    repeat (3) @(posedge clk);
    #1;
    asserts++;
    if (busy_seen || dpv_seen || n_done != 2) begin
      errors++;
      $display("FAIL zero_cfg_quiet: busy_seen=%b dpv_seen=%b dones=%0d expected 0 0 2", busy_seen, dpv_seen, n_done);
    end
  endtask

  task automatic test_random();
    bit ok;
    clear_mon();
    m_ready = 1'b1;
    start_job(3, 3, 16'h5A5A);
    drive_beats(3, 3, 300, 1'b1);
    wait_done(100, ok);
    check_job("random", 3, 3, 16'h5A5A, ok);
  endtask

  task automatic test_ignore_start();
    bit ok;
    clear_mon();
    m_ready = 1'b1;
    start_job(4, 2, 16'h3C00);
    drive_beats(4, 2, 3, 1'b0);
    cfg_h_param = 16'h4000; cfg_len = LEN_W'(1); cfg_num_ch = CH_W'(7); cfg_start = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    @(posedge clk); #1;
    asserts++;
    if (dp_h_param !== 16'h3C00) begin errors++; $display("FAIL ignore_h: got %h expected 3c00", dp_h_param); end
    drive_beats(4, 2, 50, 1'b0);
    wait_done(100, ok);
    check_job("ignore", 4, 2, 16'h3C00, ok);
  endtask

  task automatic test_midreset();
    bit ok;
    clear_mon();
    m_ready = 1'b1;
    start_job(4, 2, 16'h3C00);
    drive_beats(4, 2, 2, 1'b0);
    asserts++;
    if (n_fire != 2) begin errors++; $display("FAIL midreset_beats: got %0d expected 2", n_fire); end
    rst = 1'b1;
    #1;
    check_reset_outputs("midreset_outputs");
    $display("reset asserted mid-job after %0d beats", n_fire);
    @(posedge clk); #1;
    rst = 1'b0;
    clear_mon();
    start_job(2, 3, 16'h1234);
    drive_beats(2, 3, 50, 1'b0);
    wait_done(100, ok);
    check_job("after_reset", 2, 3, 16'h1234, ok);
    asserts++;
    if (err_ovf !== 1'b0) begin errors++; $display("FAIL after_reset_ovf: got %b expected 0", err_ovf); end
  endtask

  initial begin
    clear_mon();
    cur_len = 1;
    test_reset();
    test_basic();
    test_credits();
    test_zero_cfg();
    test_random();
    test_ignore_start();
    test_midreset();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, errors);
    $finish;
  end

endmodule

// File: doc/fm_mean_ctrl.md
FM_MEAN_CTRL -- requirements
Module: fm_mean_ctrl

Interface
REQ-001 SHALL have parameter bitwidth, default 16, element width (FP16/BF16 bit pattern).
REQ-002 SHALL have parameter N, default 8, lanes per beat.
REQ-003 SHALL have parameter LEN_W, default 16, width of beats-per-channel count.
REQ-004 SHALL have parameter CH_W, default 12, width of channel count.
REQ-005 SHALL have parameter RES_DEPTH, default 4 (power of 2, >=2), result FIFO depth and credit limit.
REQ-006 clk  in  1  sole clock, rising edge.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 cfg_start  in  1  start pulse, sampled only in IDLE.
REQ-009 cfg_len  in  LEN_W  beats per channel.
REQ-010 cfg_num_ch  in  CH_W  channels per job.
REQ-011 cfg_h_param  in  bitwidth  scale factor (1/H) for the mean datapath.
REQ-012 s_data / s_valid / s_ready  in / in / out  N*bitwidth / 1 / 1  feature-map beat stream.
REQ-013 dp_in / dp_in_valid / dp_in_last / dp_h_param  out  N*bitwidth / 1 / 1 / bitwidth  drive to mean datapath.
REQ-014 dp_out / dp_out_valid / dp_out_last  in  bitwidth / 1 / 1  datapath result, no backpressure.
REQ-015 m_data / m_valid / m_ready  out / out / in  bitwidth / 1 / 1  per-channel mean output stream.
REQ-016 busy / done / err_ovf  out  1 each  status: job active / 1-cycle completion pulse / sticky overflow.

Function
REQ-017 SHALL implement FSM states IDLE, STREAM, DRAIN.
REQ-018 IDLE: cfg_start with cfg_len!=0 and cfg_num_ch!=0 -> latch cfg_len, cfg_num_ch, cfg_h_param; credits=RES_DEPTH; counters cleared; -> STREAM next cycle.
REQ-019 IDLE: cfg_start with cfg_len==0 or cfg_num_ch==0 -> done=1 next cycle, remain IDLE, no datapath activity.
REQ-020 cfg_start outside IDLE SHALL be ignored; latched config SHALL NOT change mid-job.
REQ-021 dp_h_param SHALL equal latched cfg_h_param from STREAM entry until the job's return to IDLE.
REQ-022 s_ready SHALL be 1 only in STREAM with credits>0 and channel counter < num_ch.
REQ-023 Each s_valid&s_ready transfer SHALL produce dp_in=s_data, dp_in_valid=1 exactly one cycle later (registered); dp_in_valid=0 otherwise.
REQ-024 Beat counter SHALL increment per transfer; on beat len-1 dp_in_last=1 with that beat, beat counter wraps to 0, channel counter increments, credits decrement.
REQ-025 After the last beat of channel num_ch-1 is accepted: -> DRAIN; s_ready=0.
REQ-026 Result capture: dp_out_valid&dp_out_last SHALL push dp_out into result FIFO; dp_out_valid without dp_out_last SHALL be ignored.
REQ-027 Push into full FIFO SHALL drop data and set err_ovf (sticky until reset); unreachable under correct credits.
REQ-028 m_valid = FIFO not empty; m_data = FIFO head; pop on m_valid&m_ready; results in channel order.
REQ-029 Each pop SHALL increment credits; simultaneous pop and channel-last decrement SHALL leave credits unchanged; credits never exceed RES_DEPTH.
REQ-030 DRAIN: when popped-result count == num_ch -> done=1 for one cycle, -> IDLE.
REQ-031 busy SHALL be 1 in STREAM and DRAIN, 0 in IDLE.
REQ-032 Arithmetic: counters unsigned, no saturation needed; credit counter width clog2(RES_DEPTH)+1.

Reset
REQ-033 rst=1 SHALL asynchronously force IDLE, all counters 0, credits RES_DEPTH, FIFO empty.
REQ-034 Under reset: s_ready=0, dp_in=0, dp_in_valid=0, dp_in_last=0, dp_h_param=0, m_valid=0, m_data=0, busy=0, done=0, err_ovf=0.
REQ-035 Reset mid-job SHALL abandon the job; in-flight datapath results arriving after reset release SHALL be pushed per REQ-026 (bench resets datapath together).

Verification
REQ-036 len=4, num_ch=2, s_valid continuous, m_ready=1 -> 8 dp_in beats, dp_in_last on beats 4 and 8, 2 m_data values in order, done once.
REQ-037 len=1, num_ch=6, m_ready=0 -> exactly 4 channels accepted then s_ready=0; m_ready=1 -> remaining 2 accepted, 6 results, done.
REQ-038 cfg_len=0, cfg_start -> done next cycle, busy never 1, dp_in_valid never 1.
REQ-039 s_valid toggled randomly, len=3, num_ch=3 -> dp_in_valid mirrors accepted beats one cycle later, dp_in_last on every third.
REQ-040 cfg_start and new cfg_h_param during STREAM -> ignored, dp_h_param unchanged.
REQ-041 rst asserted mid-STREAM, 2 beats in -> outputs at reset values same cycle; new job after release completes normally, err_ovf=0.
